roll_display_buffer: RTL

ROLL_DISPLAY_BUFFER -- requirements
Module: roll_display_buffer

---
 rtl/roll_pkg.sv | 6 +
 rtl/sample_ram.sv | 20 ++
 rtl/roll_display_buffer.sv | 88 ++++++++
 3 files changed

// File: rtl/roll_pkg.sv
// roll_pkg: shared default sizes for the roll display buffer.
package roll_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int DEPTH_DEF = 640;
  localparam int ADDR_W_DEF = 10;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port sample store, one write port, one registered read port.
module sample_ram #(
  parameter int DATA_W = roll_pkg::DATA_W_DEF,
  parameter int DEPTH = roll_pkg::DEPTH_DEF,
  parameter int ADDR_W = roll_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/roll_display_buffer.sv
// roll_display_buffer: circular roll-mode sample buffer read per frame through a pointer snapshot.
// Define ROLL_HOLD_EN to let hold freeze writes and count dropped samples in drop_cnt.
module roll_display_buffer
  import roll_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_start,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_col,
  input  logic              hold,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_blank,
  output logic [ADDR_W:0]   fill,
  output logic [15:0]       drop_cnt
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  logic [ADDR_W-1:0] wr_ptr, snap_ptr, p1_addr, rd_addr;
  logic [ADDR_W:0] snap_fill, sum;
  logic p1_valid, p1_blank, rd_zero, accept, blank;
  logic [DATA_W-1:0] ram_q;
`ifdef ROLL_HOLD_EN
  assign accept = wr_en & ~hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (wr_en && hold && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign accept = wr_en;
  assign drop_cnt = '0;
`endif
  // Once the buffer has wrapped, column 0 is the oldest sample at the snapshot write pointer.
  assign sum = {1'b0, snap_ptr} + {1'b0, rd_col};
  assign rd_addr = snap_fill < DEPTH_L ? rd_col : ADDR_W'(sum >= DEPTH_L ? sum - DEPTH_L : sum);
  assign blank = {1'b0, rd_col} >= snap_fill || {1'b0, rd_col} >= DEPTH_L;
  assign rd_data = rd_zero ? '0 : ram_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill <= '0;
      snap_ptr <= '0;
      snap_fill <= '0;
      p1_valid <= 1'b0;
      p1_blank <= 1'b0;
      p1_addr <= '0;
      rd_valid <= 1'b0;
      rd_blank <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
        if (fill != DEPTH_L) fill <= fill + 1'b1;
      end
      if (frame_start) begin
        snap_ptr <= wr_ptr;
        snap_fill <= fill;
      end
      p1_valid <= rd_req;
      if (rd_req) begin
        p1_addr <= rd_addr;
        p1_blank <= blank;
      end
      rd_valid <= p1_valid;
      if (p1_valid) begin
        rd_blank <= p1_blank;
        rd_zero <= p1_blank;
      end
    end
  end
  sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(accept),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .re(p1_valid & ~p1_blank),
    .raddr(p1_addr),
    .rdata(ram_q)
  );
endmodule
